// File: rtl/vga_timing_gen.sv
// SVGA raster timing generator: registered coordinates, display enable, syncs and line/frame pulses.
// Optional build macro VGA_TIMING_TICK_EN adds an i_pix_tick pixel enable for use on a faster clock.
module vga_timing_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
`ifdef VGA_TIMING_TICK_EN
  input  logic        i_pix_tick,
`endif
  output logic [10:0] o_h_coord,
  output logic [9:0]  o_v_coord,
  output logic        o_disp_enbl,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_line_start,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_timing
      $error("vga_timing_gen: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
    end
  endgenerate

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  // Bounds are one bit wider than the counters so an end value equal to the full range cannot alias to 0.
  localparam logic [11:0] H_VIS_END = 12'(H_VISIBLE);
  localparam logic [11:0] HS_BEG    = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HS_END    = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] VS_BEG    = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic        advance;
  logic [10:0] h_reg, h_next;
  logic [9:0]  v_reg, v_next;
  logic        h_wrap;
  logic        disp_next, hsync_next, vsync_next;
  logic        disp_reg, hsync_reg, vsync_reg, line_reg, frame_reg;

`ifdef VGA_TIMING_TICK_EN
  assign advance = i_pix_tick;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    h_wrap = (h_reg == H_LAST);
    h_next = h_wrap ? 11'd0 : h_reg + 11'd1;
    v_next = v_reg;
    if (h_wrap) begin
      v_next = (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
    end
    disp_next  = ({1'b0, h_next} < H_VIS_END) && ({1'b0, v_next} < V_VIS_END);
    hsync_next = (({1'b0, h_next} >= HS_BEG) && ({1'b0, h_next} < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_next = (({1'b0, v_next} >= VS_BEG) && ({1'b0, v_next} < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
  end

  // Every output is decoded from the same next-state coordinates, so all of them describe one pixel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_reg     <= H_LAST;
      v_reg     <= V_LAST;
      disp_reg  <= 1'b0;
      hsync_reg <= ~HSYNC_POL;
      vsync_reg <= ~VSYNC_POL;
      line_reg  <= 1'b0;
      frame_reg <= 1'b0;
    end else if (advance) begin
      h_reg     <= h_next;
      v_reg     <= v_next;
      disp_reg  <= disp_next;
      hsync_reg <= hsync_next;
      vsync_reg <= vsync_next;
      line_reg  <= (h_next == 11'd0);
      frame_reg <= (h_next == 11'd0) && (v_next == 10'd0);
    end else begin
      line_reg  <= 1'b0;
      frame_reg <= 1'b0;
    end
  end

  assign o_h_coord     = h_reg;
  assign o_v_coord     = v_reg;
  assign o_disp_enbl   = disp_reg;
  assign o_hsync       = hsync_reg;
  assign o_vsync       = vsync_reg;
  assign o_line_start  = line_reg;
  assign o_frame_start = frame_reg;

endmodule
